prog_freq_divider: RTL
======================

PROG_FREQ_DIVIDER -- requirements
Module: prog_freq_divider

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of divide-ratio and period counter.
REQ-002 SHALL have parameter RESET_DIV, default 2, active ratio after reset; legal range 2..2^CNT_W-1.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on its rising edge (except REQ-021).
REQ-004 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  run request; 1 = divide, 0 = stop at the next period boundary.
REQ-006 SHALL have port div_ratio  input  CNT_W  requested divide ratio N.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe; captures div_ratio into the pending register.
REQ-008 SHALL have port div_ack  output  1  one-cycle pulse in the cycle the pending ratio becomes active.
REQ-009 SHALL have port clk_out  output  1  divided clock, registered, glitch-free.
REQ-010 SHALL have port clk_tick  output  1  one-cycle pulse in the last clk_in cycle of each clk_out period.

Function
REQ-011 SHALL implement states IDLE and RUN: IDLE->RUN when en=1 is sampled; RUN->IDLE at the end of a period (cnt=N-1) while en=0; otherwise remain in the current state.
REQ-012 In RUN, cnt SHALL count 0..N-1 and wrap to 0; clk_out SHALL be 1 while cnt<floor(N/2), else 0; output period = N clk_in cycles.
REQ-013 The first cycle of RUN SHALL have cnt=0 and clk_out=1, i.e. one clk_in cycle after en is sampled high.
REQ-014 In IDLE, cnt SHALL be 0, clk_out SHALL be 0 and clk_tick SHALL be 0; en falling mid-period SHALL never truncate a period.
REQ-015 clk_tick SHALL be 1 exactly in cycles where state=RUN and cnt=N-1.
REQ-016 div_load SHALL set the pending register; a new div_load before the pending value is applied SHALL overwrite it (last wins, only one div_ack).
REQ-017 A pending ratio SHALL become active on the cycle following the cnt=N-1 cycle in RUN, or on the cycle after capture in IDLE; div_ack SHALL pulse in that cycle.
REQ-018 Captured ratios 0 or 1 SHALL be clamped to 2.
REQ-019 div_load and period end in the same cycle SHALL apply the newly loaded value at that boundary.
REQ-020 The counter SHALL be CNT_W bits wide; cnt=N-1 comparison SHALL be exact with no overflow for N=2^CNT_W-1.

Reset
REQ-021 arstn low SHALL asynchronously force state=IDLE, cnt=0, active ratio=RESET_DIV, pending cleared, clk_out=0, clk_tick=0, div_ack=0, including the negedge flop of REQ-023.
REQ-022 Reset asserted mid-period SHALL abort the period immediately; after release, behaviour SHALL match power-up.

Configuration
REQ-023 With ODD_DUTY50_EN defined, for odd N, clk_out's high phase SHALL be extended by half a clk_in cycle using a falling-edge flop, giving exact 50 % duty; even N unchanged.
REQ-024 Without ODD_DUTY50_EN, no falling-edge logic SHALL exist and odd N gives high floor(N/2), low ceil(N/2) cycles.

Structure
REQ-025 Package freq_div_pkg SHALL hold the state enum (IDLE, RUN) and constant MIN_DIV=2.
REQ-026 Sub-module clk_duty_stretch SHALL contain the ODD_DUTY50_EN falling-edge path; the counter/FSM SHALL live in prog_freq_divider.

Verification (clk_in 100 MHz)
REQ-027 Reset then en=1 with RESET_DIV=2: clk_out 20 ns period, 50 % duty, clk_tick once every 2 cycles, first clk_out rise one cycle after en.
REQ-028 div_ratio=5, div_load mid-period of N=2: current period completes, div_ack pulses once, then clk_out high 20 ns / low 30 ns (high 25 ns with ODD_DUTY50_EN).
REQ-029 en=0 at cnt=3 of N=8: clk_out stays low after cnt=7, state IDLE, no short pulse; en=1 restarts with cnt=0.
REQ-030 div_load with div_ratio=0, then div_ratio=1: active N=2 both times, div_ack each time.
REQ-031 Two div_loads (6 then 10) within one N=16 period: single div_ack, new period = 10 cycles.
REQ-032 arstn low for 3 ns mid-period at N=10: all outputs 0 immediately; after release, active N=2 and IDLE until en sampled.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared types and constants for the programmable frequency divider.
package freq_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_duty_stretch.sv
// Duty-cycle stretcher for the divided clock.
// Build option ODD_DUTY50_EN: for odd ratios the high phase is extended by
// half a clk_in cycle using a falling-edge flop (exact 50 % duty). Without
// it the registered clock passes straight through and no falling-edge logic
// exists.
module clk_duty_stretch (
`ifdef ODD_DUTY50_EN
  input  logic clk_in,
  input  logic arstn,
  input  logic odd,
`endif
  input  logic clk_q,
  output logic clk_out
);

`ifdef ODD_DUTY50_EN
  logic half_q;

  // Half-cycle delayed copy of the high phase, only for odd ratios
  always_ff @(negedge clk_in or negedge arstn) begin
    if (!arstn) half_q <= 1'b0;
    else        half_q <= clk_q & odd;
  end

  // Overlapping OR of the two flops cannot glitch: half_q only changes
  // half a cycle away from any clk_q edge.
  assign clk_out = clk_q | half_q;
`else
  assign clk_out = clk_q;
`endif

endmodule

// File: rtl/prog_freq_divider.sv
// Programmable clock divider: IDLE/RUN FSM, period counter, pending-ratio
// register with boundary-aligned update, registered clk_out/clk_tick/div_ack.
// Build option ODD_DUTY50_EN selects exact 50 % duty for odd ratios
// (see clk_duty_stretch).
module prog_freq_divider
  import freq_div_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic             clk_in,
  input  logic             arstn,
  input  logic             en,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             clk_tick
);

  localparam logic [CNT_W-1:0] RESET_RATIO = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] MIN_RATIO   = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] ratio, ratio_nxt;
  logic [CNT_W-1:0] pend, pend_nxt;
  logic             pend_v, pend_v_nxt;
  logic [CNT_W-1:0] load_val;
  logic             period_end, apply_pt, ack_nxt;
  logic             clk_q;
`ifdef ODD_DUTY50_EN
  logic             odd_q;
`endif

  // Next-state logic: ratio update at apply points, FSM and period counter
  always_comb begin
    load_val   = (div_ratio < MIN_RATIO) ? MIN_RATIO : div_ratio;
    period_end = (state == RUN) && (cnt == ratio - ONE);
    apply_pt   = (state == IDLE) || period_end;

    ratio_nxt  = ratio;
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
    ack_nxt    = 1'b0;
    // A load coinciding with an apply point bypasses the pending register
    // so the freshest value wins.
    if (apply_pt) begin
      if (div_load) begin
        ratio_nxt  = load_val;
        pend_v_nxt = 1'b0;
        ack_nxt    = 1'b1;
      end else if (pend_v) begin
        ratio_nxt  = pend;
        pend_v_nxt = 1'b0;
        ack_nxt    = 1'b1;
      end
    end else if (div_load) begin
      pend_nxt   = load_val;
      pend_v_nxt = 1'b1;
    end

    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (period_end) begin
          cnt_nxt = '0;
          if (!en) state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State registers; outputs are registered from the next-cycle view so they
  // line up with the state/count they describe
  always_ff @(posedge clk_in or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      cnt      <= '0;
      ratio    <= RESET_RATIO;
      pend     <= '0;
      pend_v   <= 1'b0;
      clk_q    <= 1'b0;
      clk_tick <= 1'b0;
      div_ack  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ratio    <= ratio_nxt;
      pend     <= pend_nxt;
      pend_v   <= pend_v_nxt;
      clk_q    <= (state_nxt == RUN) && (cnt_nxt < (ratio_nxt >> 1));
      clk_tick <= (state_nxt == RUN) && (cnt_nxt == ratio_nxt - ONE);
      div_ack  <= ack_nxt;
    end
  end

`ifdef ODD_DUTY50_EN
  // Odd-ratio flag tracks the ratio of the current period
  always_ff @(posedge clk_in or negedge arstn) begin
    if (!arstn) odd_q <= 1'b0;
    else        odd_q <= ratio_nxt[0];
  end
`endif

  clk_duty_stretch u_stretch (
`ifdef ODD_DUTY50_EN
    .clk_in  (clk_in),
    .arstn   (arstn),
    .odd     (odd_q),
`endif
    .clk_q   (clk_q),
    .clk_out (clk_out)
  );

endmodule
